aes_state_engine: RTL

//  AES 4x4 byte state array with a START/BUSY/DONE command interface.

---
 rtl/aes_state_pkg.sv | 65 ++++++
 rtl/aes_state_engine_if.sv | 16 +
 rtl/aes_mix_column.sv | 27 ++
 rtl/aes_sbox.sv | 20 ++
 rtl/aes_state_engine.sv | 123 ++++++++++++
 5 files changed

// File: rtl/aes_state_pkg.sv
// aes_state_pkg: op codes, FSM states and GF(2^8) helpers; AES_INV_CIPHER_EN adds the inverse-cipher multipliers
package aes_state_pkg;
   localparam logic [2:0] OP_READ       = 3'b000;
   localparam logic [2:0] OP_WRITE      = 3'b001;
   localparam logic [2:0] OP_WRITE_SBOX = 3'b010;
   localparam logic [2:0] OP_SHIFT      = 3'b011;
   localparam logic [2:0] OP_MIX        = 3'b100;
   localparam logic [2:0] OP_ADDKEY     = 3'b101;
   localparam logic [2:0] OP_INV_SHIFT  = 3'b110;
   localparam logic [2:0] OP_INV_MIX    = 3'b111;

   typedef enum logic {S_IDLE, S_MIX} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] x);
      return xtime(x);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ t : p;
         t = xtime(t);
      end
      return p;
   endfunction

`ifdef AES_INV_CIPHER_EN
   function automatic logic [7:0] gmul9(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ x;
   endfunction

   function automatic logic [7:0] gmul11(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
   endfunction

   function automatic logic [7:0] gmul13(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
   endfunction

   function automatic logic [7:0] gmul14(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
   endfunction
`endif

   // byte r*4+c of the result comes from column c+r (forward) or c-r (inverse) of the same row
   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      int src;
      shift_rows = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            shift_rows[8*(4*r+c) +: 8] = s[8*(4*r+src) +: 8];
         end
   endfunction
endpackage

// File: rtl/aes_state_engine_if.sv
// aes_state_engine_if: command/data bus between the round controller and the state engine
interface aes_state_engine_if #(parameter int BUS_BYTES = 1);
   logic                   cs;
   logic                   start;
   logic [2:0]             op;
   logic [3:0]             addr;
   logic [8*BUS_BYTES-1:0] wdata;
   logic [127:0]           key;
   logic [8*BUS_BYTES-1:0] rdata;
   logic                   rvalid;
   logic                   busy;
   logic                   done;

   modport master (output cs, start, op, addr, wdata, key, input rdata, rvalid, busy, done);
   modport slave  (input cs, start, op, addr, wdata, key, output rdata, rvalid, busy, done);
endinterface

// File: rtl/aes_mix_column.sv
// aes_mix_column: one-column MixColumns (inv selects InvMixColumns when AES_INV_CIPHER_EN is defined)
module aes_mix_column
   import aes_state_pkg::*;
(
   input  logic [31:0] col_i,
   input  logic        inv,
   output logic [31:0] col_o
);
   logic [7:0] b0, b1, b2, b3;

   // byte r of the column sits at bits 8r+7:8r; output row r rotates the coefficient row
   always_comb begin
      col_o = '0;
      for (int r = 0; r < 4; r++) begin
         b0 = col_i[8*r +: 8];
         b1 = col_i[8*((r+1)%4) +: 8];
         b2 = col_i[8*((r+2)%4) +: 8];
         b3 = col_i[8*((r+3)%4) +: 8];
`ifdef AES_INV_CIPHER_EN
         col_o[8*r +: 8] = inv ? gmul14(b0) ^ gmul11(b1) ^ gmul13(b2) ^ gmul9(b3)
                               : gmul2(b0) ^ gmul3(b1) ^ b2 ^ b3;
`else
         col_o[8*r +: 8] = inv ? b0 : gmul2(b0) ^ gmul3(b1) ^ b2 ^ b3;
`endif
      end
   end
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box as GF(2^8) inverse followed by the affine transform
module aes_sbox
   import aes_state_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] sq, iv;

   // inverse as x^254 = product of x^(2^i), i=1..7; zero maps to zero naturally
   always_comb begin
      sq = a;
      iv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         iv = gmul(iv, sq);
      end
      y = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
   end
endmodule

// File: rtl/aes_state_engine.sv
// aes_state_engine: AES 4x4 state array with START/BUSY/DONE commands; AES_INV_CIPHER_EN enables OP 110/111
module aes_state_engine
   import aes_state_pkg::*;
#(
   parameter int BUS_BYTES    = 1,
   parameter int MIX_COLS_PER = 1
) (
   input logic                clk,
   input logic                rst_n,
   aes_state_engine_if.slave  bus
);
   localparam int NG = 4 / MIX_COLS_PER;
   localparam int BW = 8 * BUS_BYTES;

   state_e                  state_q, state_d;
   logic [127:0]            st_q, st_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    inv_q, inv_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    rvalid_q, rvalid_d;
   logic [BW-1:0]           rdata_q, rdata_d;
   logic [BW-1:0]           sb;
   logic [3:0]              base;
   logic                    accept, mix_op, last;
   logic [32*MIX_COLS_PER-1:0] mix_in, mix_out;

   assign base   = bus.addr & ~4'(BUS_BYTES - 1);
   assign accept = state_q == S_IDLE && bus.cs && bus.start;
   assign last   = cnt_q == 2'(NG - 1);
`ifdef AES_INV_CIPHER_EN
   assign mix_op = bus.op == OP_MIX || bus.op == OP_INV_MIX;
`else
   assign mix_op = bus.op == OP_MIX;
`endif

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

   for (genvar i = 0; i < BUS_BYTES; i++) begin : g_lane
      aes_sbox u_sbox (.a(bus.wdata[8*i +: 8]), .y(sb[8*i +: 8]));
   end

   for (genvar j = 0; j < MIX_COLS_PER; j++) begin : g_mix
      logic [1:0] mcol;
      assign mcol = 2'(int'(cnt_q) * MIX_COLS_PER + j);
      assign mix_in[32*j +: 32] = {st_q[8*(12 + int'(mcol)) +: 8], st_q[8*(8 + int'(mcol)) +: 8],
                                   st_q[8*(4 + int'(mcol)) +: 8], st_q[8*int'(mcol) +: 8]};
      aes_mix_column u_mix (.col_i(mix_in[32*j +: 32]), .inv(inv_q), .col_o(mix_out[32*j +: 32]));
   end

   // next state: column-group writeback while mixing, otherwise decode an accepted command
   always_comb begin
      state_d  = state_q;
      st_d     = st_q;
      cnt_d    = cnt_q;
      inv_d    = inv_q;
      busy_d   = busy_q;
      rdata_d  = '0;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
      if (state_q == S_MIX) begin
         for (int j = 0; j < MIX_COLS_PER; j++)
            for (int r = 0; r < 4; r++)
               st_d[8*(4*r + int'(cnt_q)*MIX_COLS_PER + j) +: 8] = mix_out[32*j + 8*r +: 8];
         cnt_d   = last ? 2'd0 : cnt_q + 2'd1;
         state_d = last ? S_IDLE : S_MIX;
         busy_d  = !last;
         done_d  = last;
      end else if (accept) begin
         done_d = !mix_op;
         case (bus.op)
            OP_READ: begin
               for (int i = 0; i < BUS_BYTES; i++) rdata_d[8*i +: 8] = st_q[8*(int'(base) + i) +: 8];
               rvalid_d = 1'b1;
            end
            OP_WRITE:
               for (int i = 0; i < BUS_BYTES; i++) st_d[8*(int'(base) + i) +: 8] = bus.wdata[8*i +: 8];
            OP_WRITE_SBOX:
               for (int i = 0; i < BUS_BYTES; i++) st_d[8*(int'(base) + i) +: 8] = sb[8*i +: 8];
            OP_SHIFT:  st_d = shift_rows(st_q, 1'b0);
            OP_ADDKEY: st_d = st_q ^ bus.key;
`ifdef AES_INV_CIPHER_EN
            OP_INV_SHIFT: st_d = shift_rows(st_q, 1'b1);
            OP_MIX, OP_INV_MIX: begin
`else
            OP_MIX: begin
`endif
               state_d = S_MIX;
               busy_d  = 1'b1;
               cnt_d   = 2'd0;
               inv_d   = bus.op == OP_INV_MIX;
            end
            default: ;
         endcase
      end
   end

   // state and registered outputs; reset clears everything including a partial mix
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         st_q     <= '0;
         cnt_q    <= 2'd0;
         inv_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         inv_q    <= inv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end
endmodule
